// File: rtl/cache_mem_arbiter_if.sv
// Bundle of cache-side request/fill signals and memory-side bus signals seen by the arbiter.
// The master modport is the arbiter; the slave modport is the caches plus memory.
interface cache_mem_arbiter_if;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_data_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_valid;
  logic        d_fill_valid;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        d_wr_ack;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
    input  mem_rdata, mem_data_valid,
    output mem_addr, mem_enable, mem_wr, mem_wdata,
    output fill_data, fill_word, i_fill_valid, d_fill_valid, i_fill_done, d_fill_done,
    output d_wr_ack
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
    output mem_rdata, mem_data_valid,
    input  mem_addr, mem_enable, mem_wr, mem_wdata,
    input  fill_data, fill_word, i_fill_valid, d_fill_valid, i_fill_done, d_fill_done,
    input  d_wr_ack
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises I/D block fills and D write-through onto one pipelined memory (fixed priority
// write > D miss > I miss), issuing all word reads back-to-back and steering returns to the owner.
module cache_mem_arbiter #(
  parameter int unsigned WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_mem_arbiter_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StWrite, StIssue, StDrain} state_e;
  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  state_e      state_q;
  owner_e      owner_q;
  logic [15:0] base_q;
  logic [3:0]  issue_cnt_q;
  logic [3:0]  ret_cnt_q;

  logic ret_hit;
  logic ret_last;
  logic issue_last;

  // Returns are only meaningful while a fill owns the memory; stray valids are dropped.
  assign ret_hit    = bus.mem_data_valid && (owner_q != OwnNone);
  assign ret_last   = ret_hit && (ret_cnt_q == 4'(WORDS - 1));
  assign issue_last = (issue_cnt_q == 4'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnNone;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      if (ret_hit) ret_cnt_q <= ret_cnt_q + 4'd1;

      unique case (state_q)
        StIdle: begin
          if (bus.d_wr_req) begin
            state_q <= StWrite;
          end else if (bus.d_miss) begin
            state_q     <= StIssue;
            owner_q     <= OwnD;
            base_q      <= bus.d_miss_addr & 16'hFFF0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
          end else if (bus.i_miss) begin
            state_q     <= StIssue;
            owner_q     <= OwnI;
            base_q      <= bus.i_miss_addr & 16'hFFF0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
          end
        end
        StWrite: state_q <= StIdle;
        StIssue: begin
          issue_cnt_q <= issue_cnt_q + 4'd1;
          if (issue_last) state_q <= StDrain;
        end
        StDrain: state_q <= StDrain;
      endcase

      // Final return ends the fill regardless of which phase it lands in.
      if (ret_last) begin
        owner_q <= OwnNone;
        state_q <= StIdle;
      end
    end
  end

  always_comb begin
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.d_wr_ack   = 1'b0;
    unique case (state_q)
      StWrite: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = bus.d_wr_addr;
        bus.mem_wdata  = bus.d_wr_data;
        bus.d_wr_ack   = 1'b1;
      end
      StIssue: begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = base_q + {11'd0, issue_cnt_q, 1'b0};
      end
      StIdle, StDrain: begin
        bus.mem_enable = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.fill_data    = bus.mem_rdata;
    bus.fill_word    = ret_hit ? ret_cnt_q[2:0] : 3'd0;
    bus.i_fill_valid = ret_hit && (owner_q == OwnI);
    bus.d_fill_valid = ret_hit && (owner_q == OwnD);
    bus.i_fill_done  = ret_last && (owner_q == OwnI);
    bus.d_fill_done  = ret_last && (owner_q == OwnD);
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized checks of cache_mem_arbiter against a cycle-numbered reference
// of the fill/write timeline, with a fixed-latency memory whose contents are a hash of address.
module tb_cache_mem_arbiter;
  localparam int MEM_LATENCY = 4;
  localparam int WORDS       = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned salt     = 0;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a * 16'd40503) ^ salt[15:0];
  endfunction

  // Memory: read sampled mid-cycle, data returned MEM_LATENCY cycles after the issue cycle.
  logic                 s_en   = 1'b0;
  logic [15:0]          s_addr = '0;
  logic [MEM_LATENCY-1:0] pv   = '0;
  logic [15:0]          pd [MEM_LATENCY];
  logic                 spur      = 1'b0;
  logic [15:0]          spur_data = '0;

  always @(negedge clk) begin
    s_en   <= bus.mem_enable && !bus.mem_wr;
    s_addr <= bus.mem_addr;
  end

  always @(posedge clk) begin
    pv    <= {pv[MEM_LATENCY-2:0], s_en};
    pd[0] <= mem_f(s_addr);
    for (int k = 1; k < MEM_LATENCY; k++) pd[k] <= pd[k-1];
  end

  assign bus.mem_data_valid = pv[MEM_LATENCY-1] | spur;
  assign bus.mem_rdata      = spur ? spur_data : pd[MEM_LATENCY-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".mem_enable"}, 32'(bus.mem_enable), 0);
    chk({tag, ".mem_wr"},     32'(bus.mem_wr), 0);
    chk({tag, ".mem_addr"},   32'(bus.mem_addr), 0);
    chk({tag, ".mem_wdata"},  32'(bus.mem_wdata), 0);
    chk({tag, ".i_valid"},    32'(bus.i_fill_valid), 0);
    chk({tag, ".d_valid"},    32'(bus.d_fill_valid), 0);
    chk({tag, ".i_done"},     32'(bus.i_fill_done), 0);
    chk({tag, ".d_done"},     32'(bus.d_fill_done), 0);
    chk({tag, ".wr_ack"},     32'(bus.d_wr_ack), 0);
  endtask

  task automatic clear_reqs();
    bus.i_miss = 1'b0; bus.i_miss_addr = '0;
    bus.d_miss = 1'b0; bus.d_miss_addr = '0;
    bus.d_wr_req = 1'b0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
  endtask

  // Called in an IDLE cycle; the request is seen at edge 0, then cycles 1..8+L are checked.
  task automatic run_miss(input bit is_d, input logic [15:0] addr, input int drop_cyc);
    logic [15:0] base;
    logic        own_v, own_d, oth_v, oth_d, exp_en;
    bit          rv;
    base = addr & 16'hFFF0;
    if (is_d) begin bus.d_miss = 1'b1; bus.d_miss_addr = addr; end
    else      begin bus.i_miss = 1'b1; bus.i_miss_addr = addr; end
    for (int c = 1; c <= WORDS + MEM_LATENCY; c++) begin
      step();
      if (drop_cyc != 0 && c == drop_cyc) begin
        if (is_d) bus.d_miss = 1'b0; else bus.i_miss = 1'b0;
      end
      exp_en = (c <= WORDS);
      rv     = (c >= 1 + MEM_LATENCY);
      own_v  = is_d ? bus.d_fill_valid : bus.i_fill_valid;
      own_d  = is_d ? bus.d_fill_done  : bus.i_fill_done;
      oth_v  = is_d ? bus.i_fill_valid : bus.d_fill_valid;
      oth_d  = is_d ? bus.i_fill_done  : bus.d_fill_done;
      chk("rd.mem_enable", 32'(bus.mem_enable), 32'(exp_en));
      chk("rd.mem_wr",     32'(bus.mem_wr), 0);
      chk("rd.mem_addr",   32'(bus.mem_addr), exp_en ? 32'(base + 16'(2 * (c - 1))) : 0);
      chk("rd.mem_wdata",  32'(bus.mem_wdata), 0);
      chk("rd.wr_ack",     32'(bus.d_wr_ack), 0);
      chk("fill.own_valid", 32'(own_v), 32'(rv));
      chk("fill.own_done",  32'(own_d), 32'(c == WORDS + MEM_LATENCY));
      chk("fill.oth_valid", 32'(oth_v), 0);
      chk("fill.oth_done",  32'(oth_d), 0);
      if (rv) begin
        chk("fill.word", 32'(bus.fill_word), 32'(c - 1 - MEM_LATENCY));
        chk("fill.data", 32'(bus.fill_data),
            32'(mem_f(base + 16'(2 * (c - 1 - MEM_LATENCY)))));
      end
    end
    if (is_d) bus.d_miss = 1'b0; else bus.i_miss = 1'b0;
  endtask

  // Called in an IDLE cycle; write occupies cycle 1, cycle 2 is IDLE again.
  task automatic run_write(input logic [15:0] addr, input logic [15:0] data);
    bus.d_wr_req = 1'b1; bus.d_wr_addr = addr; bus.d_wr_data = data;
    step();
    chk("wr.mem_enable", 32'(bus.mem_enable), 1);
    chk("wr.mem_wr",     32'(bus.mem_wr), 1);
    chk("wr.mem_addr",   32'(bus.mem_addr), 32'(addr));
    chk("wr.mem_wdata",  32'(bus.mem_wdata), 32'(data));
    chk("wr.ack",        32'(bus.d_wr_ack), 1);
    chk("wr.i_valid",    32'(bus.i_fill_valid), 0);
    chk("wr.d_valid",    32'(bus.d_fill_valid), 0);
    bus.d_wr_req = 1'b0;
    step();
    idle_chk("wr.after");
  endtask

  initial begin
    salt = $urandom;
    clear_reqs();

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.i_miss = 1'($urandom); bus.i_miss_addr = 16'($urandom);
      bus.d_miss = 1'($urandom); bus.d_miss_addr = 16'($urandom);
      bus.d_wr_req = 1'($urandom); bus.d_wr_addr = 16'($urandom);
      bus.d_wr_data = 16'($urandom);
      spur = 1'($urandom); spur_data = 16'($urandom);
      step();
      idle_chk("rst");
      chk("rst.fill_word", 32'(bus.fill_word), 0);
      chk("rst.fill_data", 32'(bus.fill_data), 32'(bus.mem_rdata));
    end
    spur = 1'b0;
    clear_reqs();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      idle_chk("idle");
      chk("idle.fill_word", 32'(bus.fill_word), 0);
    end

    // I-miss at 0x1237.
    run_miss(1'b0, 16'h1237, 0);
    step();
    idle_chk("imiss.after");

    // Simultaneous write, D miss, I miss: write, then D block, then I block.
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h2008;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0100;
    run_write(16'h4000, 16'hBEEF);
    run_miss(1'b1, 16'h2008, 0);
    step();
    idle_chk("prio.mid");
    run_miss(1'b0, 16'h0100, 0);
    step();
    idle_chk("prio.after");

    // I-miss dropped after two ISSUE cycles still completes.
    run_miss(1'b0, 16'h5A5A, 3);
    step();
    idle_chk("drop.after");

    // Spurious return while IDLE is ignored and does not advance the word counter.
    spur = 1'b1; spur_data = 16'($urandom);
    #1;
    idle_chk("spur");
    chk("spur.fill_data", 32'(bus.fill_data), 32'(spur_data));
    step();
    spur = 1'b0;
    idle_chk("spur.after");

    // Reset during cycle 6 of a D fill; remaining returns must be dropped.
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h3C40;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("rstmid.issue", 32'(bus.mem_enable), 1);
    end
    chk("rstmid.d_valid5", 32'(bus.d_fill_valid), 1);
    chk("rstmid.word5",    32'(bus.fill_word), 0);
    step();
    rst_n = 1'b0;
    bus.d_miss = 1'b0;
    #1;
    idle_chk("rstmid.c6");
    for (int c = 7; c <= 14; c++) begin
      step();
      if (c == 8) rst_n = 1'b1;
      idle_chk("rstmid.tail");
    end
    run_miss(1'b0, 16'h0A26, 0);
    step();
    idle_chk("rstmid.after");

    // Block at the top of the address space must not wrap.
    run_miss(1'b1, 16'hFFF7, 0);
    step();
    idle_chk("top.after");

    // Randomized mix of writes and misses.
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0: run_write(16'($urandom), 16'($urandom));
        1: begin run_miss(1'b1, 16'($urandom), 0); step(); idle_chk("rnd.d"); end
        default: begin run_miss(1'b0, 16'($urandom), 0); step(); idle_chk("rnd.i"); end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single pipelined main memory between the I-cache and D-cache miss handlers, and the D-cache write-through path. It sits between the two cache fill FSMs (downstream) and the memory (upstream). On a miss it issues every word read of the 16-byte block back-to-back, then steers the returning data and valid strobes to the owning cache. Fill and write requests are serialised with fixed priority, and the block tracks outstanding reads.

## Interface
- MEM_LATENCY, 4, cycles from a read issue (mem_enable=1, mem_wr=0) to its mem_data_valid
- WORDS, 8, 16-bit words per cache block (block = 16 bytes)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- i_miss  in  1  I-cache miss request (level, held while I fill FSM busy)
- i_miss_addr  in  16  I-cache miss byte address
- d_miss  in  1  D-cache miss request (level)
- d_miss_addr  in  16  D-cache miss byte address
- d_wr_req  in  1  D-cache write-through request (level)
- d_wr_addr  in  16  write byte address
- d_wr_data  in  16  write data
- mem_addr  out  16  memory byte address
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read (valid only with mem_enable)
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_data_valid  in  1  mem_rdata valid this cycle
- fill_data  out  16  mem_rdata passed through to both caches
- fill_word  out  3  word index (0..7) of the current fill_data
- i_fill_valid / d_fill_valid  out  1  fill_data belongs to the I-cache / D-cache fill
- i_fill_done / d_fill_done  out  1  one-cycle pulse with the last word of the block
- d_wr_ack  out  1  one-cycle pulse when the write is issued to memory

## Operation
- States: IDLE, WRITE, ISSUE, DRAIN. Registers: owner (NONE/I/D), base[15:0], issue_cnt[3:0], ret_cnt[3:0].
- IDLE arbitration uses fixed priority: d_wr_req > d_miss > i_miss. The winner is latched at the clock edge.
  - Write winner -> WRITE.
  - Miss winner -> ISSUE with base = addr & 16'hFFF0, owner set, and both counters cleared.
- WRITE lasts one cycle.
  - Drives mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, and d_wr_ack=1.
  - Next state is IDLE.
  - If d_wr_req is still high in the next IDLE, it is a new request.
- ISSUE issues one read per cycle.
  - Each cycle drives mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt, then increments issue_cnt.
  - After the read with issue_cnt=7: DRAIN, or IDLE if the final return already occurred.
- Returns are handled in any state while owner≠NONE:
  - Each mem_data_valid: fill_data=mem_rdata, fill_word=ret_cnt[2:0], owner's *_fill_valid=1, ret_cnt increments.
  - On ret_cnt=7 with valid: owner's *_fill_done=1 in the same cycle. Next cycle owner=NONE and state=IDLE.
- No new arbitration occurs while owner≠NONE. Requests wait, and the level-held requests make this lossless.
- A client that deasserts its request mid-fill does not abort the fill. All 8 words return and fill_done still pulses.
- mem_data_valid with owner=NONE is ignored: no valid or done output, counters unchanged.
- mem_wdata is 0 unless in WRITE. mem_addr is 0 when mem_enable=0.
- fill_data = mem_rdata, combinational pass-through.
- Address arithmetic is 16-bit and wraps. base + 14 never carries past the 16-byte-aligned block.

## Timing
- Reset state: IDLE, owner=NONE, counters 0. All outputs 0: mem_enable, mem_wr, mem_addr, mem_wdata, fill_word, *_fill_valid, *_fill_done, d_wr_ack.
  - fill_data follows mem_rdata.
- Reset asserted mid-fill aborts immediately. Returns arriving after reset are ignored (owner=NONE).
- Miss request seen in IDLE at edge 0:
  - Reads are issued in cycles 1..8.
  - Valids arrive in cycles 1+MEM_LATENCY..8+MEM_LATENCY, which is 5..12 for the default.
  - Done pulses in cycle 12 and arbitration resumes in cycle 13.
- Write latency: d_wr_req in IDLE -> mem write and d_wr_ack in the next cycle. The next arbitration is one cycle after that.
- Back-to-back: the earliest next grant is evaluated in the cycle after the *_fill_done or d_wr_ack cycle.
- Simultaneous d_wr_req, d_miss, and i_miss: the write is served, then the D fill, then the I fill.
- Output assertion rules:
  - *_fill_valid, *_fill_done, and d_wr_ack are never asserted when the corresponding client is not the owner.
  - I-side and D-side outputs are never high in the same cycle.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n=0 with random inputs, then release with no requests.
  - Required: all outputs 0, no mem_enable for 20 cycles.
- I-miss at 16'h1237:
  - Required: reads to 1230,1232,…,123E in cycles 1–8.
  - Required: memory returns 8 words; i_fill_valid occurs with fill_word 0..7 in cycles 5–12.
  - Required: i_fill_done only in cycle 12; d_fill_valid stays 0.
- Simultaneous d_wr_req (addr 0x4000, data 0xBEEF), d_miss (0x2008), i_miss (0x0100):
  - Required: write issued first with d_wr_ack.
  - Required: D block 0x2000 filled completely next, then I block 0x0100.
- i_miss deasserted after 2 cycles of ISSUE:
  - Required: all 8 reads are still issued and all 8 returns are routed.
  - Required: i_fill_done still pulses.
- Spurious mem_data_valid while IDLE, and reset asserted at cycle 6 of a D fill:
  - Required: no *_fill_valid or *_fill_done for the remaining returns.
  - Required: after release, a new I-miss completes normally.
- Miss at base 0xFFF0:
  - Required: addresses FFF0..FFFE, with no wrap into 0x0000.
